// File: rtl/imem_stream_loader.sv
// Sequential program loader for cpu_pipelined instruction memory.
// Accepts a stream of instruction words, writes them from word address 0,
// appends HALT_WORD, then releases the CPU reset after RELEASE_DELAY cycles.
//
// Handshake: a beat transfers on a rising edge where s_valid && s_ready.
// s_ready never depends on s_valid. The producer holds s_data/s_last stable
// while s_valid is high and s_ready is low.
module imem_stream_loader #(
  parameter int          ADDR_WIDTH    = 10,
  parameter int          DEPTH         = 1024,
  parameter logic [31:0] HALT_WORD     = 32'h0000_0000,
  parameter int          RELEASE_DELAY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [31:0]           s_data,
  input  logic                  s_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow,
  output logic [1:0]            state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_TERM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Last memory slot is reserved for the halt word.
  localparam logic [ADDR_WIDTH:0] LAST_SLOT  = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [7:0]          DELAY_LAST = 8'(RELEASE_DELAY - 1);

  logic [1:0]            state_q,      state_d;
  logic                  imem_we_q,    imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q,  imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  cpu_reset_q,  cpu_reset_d;
  logic                  done_q,       done_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic                  overflow_q,   overflow_d;
  logic [7:0]            delay_q,      delay_d;

  logic                  accept;
  logic [ADDR_WIDTH:0]   wc_inc;

  assign s_ready = (state_q == S_LOAD) && (word_count_q < LAST_SLOT);
  assign accept  = s_valid && s_ready;
  assign wc_inc  = word_count_q + (ADDR_WIDTH+1)'(1);

  // Next-state and next-output computation for the load sequence.
  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_reset_d  = cpu_reset_q;
    done_d       = done_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    delay_d      = delay_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_LOAD;
          word_count_d = '0;
          overflow_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = word_count_q[ADDR_WIDTH-1:0];
          imem_wdata_d = s_data;
          word_count_d = wc_inc;
          if (s_last) begin
            state_d = S_TERM;
          end else if (wc_inc == LAST_SLOT) begin
            // Program does not fit: truncate and still terminate with halt.
            overflow_d = 1'b1;
            state_d    = S_TERM;
          end
        end
      end
      S_TERM: begin
        imem_we_d    = 1'b1;
        imem_addr_d  = word_count_q[ADDR_WIDTH-1:0];
        imem_wdata_d = HALT_WORD;
        done_d       = 1'b1;
        delay_d      = '0;
        state_d      = S_DONE;
      end
      default: begin
        if (start) begin
          state_d      = S_LOAD;
          cpu_reset_d  = 1'b1;
          done_d       = 1'b0;
          word_count_d = '0;
          overflow_d   = 1'b0;
          delay_d      = '0;
        end else if (cpu_reset_q) begin
          // delay_q counts DONE cycles already spent; release on the last one.
          if (delay_q == DELAY_LAST) begin
            cpu_reset_d = 1'b0;
          end else begin
            delay_d = delay_q + 8'd1;
          end
        end
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      delay_q      <= '0;
    end else begin
      state_q      <= state_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
      delay_q      <= delay_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign word_count = word_count_q;
  assign overflow   = overflow_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Bench for imem_stream_loader: directed load table, randomized loads against
// a program-level model, and hand-written reset/idle sequences.
module tb_imem_stream_loader;

  localparam int          AW    = 3;
  localparam int          DEPTH = 4;
  localparam int          RD    = 4;
  localparam logic [31:0] HALT  = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          start, s_valid, s_last;
  logic [31:0]   s_data;
  logic          s_ready, imem_we, cpu_reset, done, overflow;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;
  logic [1:0]    state_dbg;

  imem_stream_loader #(
    .ADDR_WIDTH(AW), .DEPTH(DEPTH), .HALT_WORD(HALT), .RELEASE_DELAY(RD)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .done(done), .word_count(word_count),
    .overflow(overflow), .state_dbg(state_dbg)
  );

  int total = 0;
  int bad   = 0;

  // Expected memory writes in order: {address, data}.
  logic [AW+31:0] exp_q[$];
  logic [31:0]    prog[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard: every write must match the queue head ----
  always @(negedge clk) begin
    logic [AW+31:0] e;
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr=%0d data=0x%08h, none expected", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write", {imem_addr, imem_wdata}, e);
      end
    end
  end

  // ---------------- driver: one full program load ----------------
  task automatic do_load(input int n, input bit last, input int gap,
                         input int exp_wc, input bit exp_ovf, input string tag);
    int waited;
    for (int i = 0; i < exp_wc; i++) exp_q.push_back({AW'(i), prog[i]});
    exp_q.push_back({AW'(exp_wc), HALT});

    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_start_cpu_reset"}, cpu_reset, 1);
    check({tag, "_start_done"}, done, 0);
    check({tag, "_start_wc"}, word_count, 0);
    check({tag, "_start_ovf"}, overflow, 0);

    for (int i = 0; i < exp_wc; i++) begin
      s_valid = 1'b1;
      s_data  = prog[i];
      s_last  = last && (i == n - 1);
      waited  = 0;
      forever begin
        @(negedge clk);
        if (s_ready === 1'b1) break;
        waited++;
        if (waited > 40) begin
          check({tag, "_accept_timeout"}, 0, 1);
          break;
        end
      end
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (i != exp_wc - 1) repeat (gap) step();
    end

    if (exp_ovf) begin
      // Extra word offered during TERM must be refused.
      s_valid = 1'b1;
      s_data  = $urandom;
      @(negedge clk);
      check({tag, "_ovf_s_ready"}, s_ready, 0);
      step();
      s_valid = 1'b0;
    end

    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (done !== 1'b1 && waited < 40);
    check({tag, "_done"}, done, 1);
    check({tag, "_wc"}, word_count, exp_wc);
    check({tag, "_ovf"}, overflow, exp_ovf);
    check({tag, "_cpu_reset_held"}, cpu_reset, 1);

    waited = 0;
    while (cpu_reset === 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_release_delay"}, waited, RD);
    repeat (2) @(negedge clk);
    check({tag, "_cpu_reset_stays"}, cpu_reset, 0);
    check({tag, "_done_stays"}, done, 1);
    check({tag, "_writes_drained"}, exp_q.size(), 0);
    step();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int n;
    bit last;
    int gap;
    int exp_wc;
    bit exp_ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gap, acc;
    bit last, ovf;

    vecs[0] = '{n: 3, last: 1, gap: 0, exp_wc: 3, exp_ovf: 0};  // basic load
    vecs[1] = '{n: 3, last: 1, gap: 2, exp_wc: 3, exp_ovf: 0};  // bubbles
    vecs[2] = '{n: 6, last: 0, gap: 0, exp_wc: 3, exp_ovf: 1};  // overflow
    vecs[3] = '{n: 1, last: 1, gap: 0, exp_wc: 1, exp_ovf: 0};  // reload
    vecs[4] = '{n: 4, last: 1, gap: 1, exp_wc: 3, exp_ovf: 1};  // last lands past end
    vecs[5] = '{n: 3, last: 0, gap: 0, exp_wc: 3, exp_ovf: 1};  // exact fit, no last
    vecs[6] = '{n: 2, last: 1, gap: 3, exp_wc: 2, exp_ovf: 0};

    reset   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    repeat (3) step();
    check("rst_s_ready", s_ready, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_done", done, 0);
    check("rst_wc", word_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b1;
    step();

    // Stream activity while idle is ignored.
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    repeat (5) begin
      @(negedge clk);
      check("idle_s_ready", s_ready, 0);
      check("idle_imem_we", imem_we, 0);
      check("idle_wc", word_count, 0);
      check("idle_cpu_reset", cpu_reset, 1);
    end
    step();
    s_valid = 1'b0;

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 8; i++) prog[i] = $urandom;
      if (v <= 1) begin
        prog[0] = 32'h0000_0463;
        prog[1] = 32'h0030_0313;
        prog[2] = 32'h0040_0293;
      end
      if (v == 3) prog[0] = 32'h0010_0093;
      do_load(vecs[v].n, vecs[v].last, vecs[v].gap, vecs[v].exp_wc, vecs[v].exp_ovf,
              $sformatf("vec%0d", v));
    end

    // Randomized loads checked against the program-level model.
    for (int r = 0; r < 20; r++) begin
      n    = $urandom_range(1, 6);
      last = (n < DEPTH - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      gap  = $urandom_range(0, 2);
      for (int i = 0; i < 8; i++) prog[i] = $urandom;
      acc = (n < DEPTH - 1) ? n : DEPTH - 1;
      ovf = (n > DEPTH - 1) || (n == DEPTH - 1 && !last);
      do_load(n, last, gap, acc, ovf, $sformatf("rnd%0d", r));
    end

    // Reset in the middle of a load.
    prog[0] = 32'h0000_0463;
    prog[1] = 32'h0030_0313;
    prog[2] = 32'h0040_0293;
    exp_q.push_back({AW'(0), prog[0]});
    exp_q.push_back({AW'(1), prog[1]});
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = prog[i];
      @(negedge clk);
      check("mid_s_ready", s_ready, 1);
      step();
    end
    s_data = prog[2];
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_cpu_reset", cpu_reset, 1);
    check("mid_rst_s_ready", s_ready, 0);
    check("mid_rst_imem_we", imem_we, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_wc", word_count, 0);
    check("mid_rst_state", state_dbg, 0);
    check("mid_rst_writes", exp_q.size(), 0);
    repeat (2) step();
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_s_ready", s_ready, 0);
      check("post_rst_state", state_dbg, 0);
      check("post_rst_cpu_reset", cpu_reset, 1);
    end
    step();
    s_valid = 1'b0;

    // Normal load after the abort.
    do_load(3, 1'b1, 1, 3, 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
